imem_fetch_buf: RTL and testbench

- Parametrised successor to the single-cycle instruction memory.
- Adds a load (boot) write port and a registered, stallable fetch output with a valid/ready handshake.
- Adds configurable word width and depth, address wrap modulo depth, misalignment detection and a delivered-instruction counter.
- Sits between the PC/fetch logic and the decode stage of the MIPS datapath.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_array.sv | 49 ++++
 rtl/imem_fetch_buf.sv | 88 ++++++++
 tb/tb_imem_fetch_buf.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants for the instruction memory and decode
package imem_pkg;

  // Default widths for the instruction path
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  // Word driven in place of an instruction when the fetch address is misaligned
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Instruction field positions, reused by the decode stage
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  // Extract the primary opcode field of an instruction word
  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage with modulo indexing and write-first bypass
module imem_array import imem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] radr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

  // Word index of a byte address; the mod keeps every address inside the array
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-3:0] word_adr);
    return IDX_W'(word_adr % DEPTH_W);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic              unused_adr_lsb;

  assign widx = idx_of(wadr[ADDR_W-1:2]);
  assign ridx = idx_of(radr[ADDR_W-1:2]);

  // Byte-offset bits carry no meaning for word storage
  assign unused_adr_lsb = ^{wadr[1:0], radr[1:0]};

  // Storage write; contents survive reset so a booted program stays loaded
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  // Combinational read; a same-cycle write to the same word is forwarded
  always_comb begin
    rdata = mem_q[ridx];
    if (we && (widx == ridx)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/imem_fetch_buf.sv
// rtl/imem_fetch_buf.sv - stallable registered instruction fetch with boot load port
module imem_fetch_buf import imem_pkg::*; #(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DEPTH    = 9,
  parameter int                 CNT_W    = 16,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_adr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic [DATA_W-1:0] rd_word;
  logic              accept;
  logic              deliver;
  logic              misaligned;

  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic              misalign_err_q, misalign_err_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  imem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .wadr  (load_adr),
    .wdata (load_data),
    .radr  (fetch_adr),
    .rdata (rd_word)
  );

  // A held word blocks new requests only while downstream is stalled
  assign fetch_ready = !(inst_valid_q && stall);
  assign accept      = fetch_req && fetch_ready;
  assign deliver     = inst_valid_q && !stall;
  assign misaligned  = (fetch_adr[1:0] != 2'b00);

  // Next state of the output register and delivery counter
  always_comb begin
    inst_valid_d   = inst_valid_q;
    inst_out_d     = inst_out_q;
    misalign_err_d = misalign_err_q;
    fetch_cnt_d    = fetch_cnt_q + CNT_W'(deliver);
    if (accept) begin
      inst_valid_d   = 1'b1;
      misalign_err_d = misaligned;
      inst_out_d     = misaligned ? NOP_WORD : rd_word;
    end else if (deliver) begin
      inst_valid_d = 1'b0;
    end
  end

  // Output register and counter; reset clears them but not the memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_valid_q   <= 1'b0;
      inst_out_q     <= '0;
      misalign_err_q <= 1'b0;
      fetch_cnt_q    <= '0;
    end else begin
      inst_valid_q   <= inst_valid_d;
      inst_out_q     <= inst_out_d;
      misalign_err_q <= misalign_err_d;
      fetch_cnt_q    <= fetch_cnt_d;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst_out     = inst_out_q;
  assign misalign_err = misalign_err_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_buf.sv
// tb/tb_imem_fetch_buf.sv - directed self-checking bench for imem_fetch_buf
module tb_imem_fetch_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [31:0] load_adr;
  logic [31:0] load_data;
  logic        fetch_req;
  logic [31:0] fetch_adr;
  logic        fetch_ready;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic        misalign_err;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [9];

  imem_fetch_buf #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (9),
    .CNT_W    (16),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_adr     (load_adr),
    .load_data    (load_data),
    .fetch_req    (fetch_req),
    .fetch_adr    (fetch_adr),
    .fetch_ready  (fetch_ready),
    .stall        (stall),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_en = 1'b0; load_adr = '0; load_data = '0;
    fetch_req = 1'b0; fetch_adr = '0; stall = 1'b0;
    tick(); tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
    checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fetch_cnt); end
    reset = 1'b0;
    #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fetch_ready); end
  endtask

  task automatic load_program();
    for (int i = 0; i < 9; i++) begin
      load_en = 1'b1; load_adr = 32'(4 * i); load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 9; i++) begin
      fetch_req = 1'b1; fetch_adr = 32'(4 * i);
      tick();
      checks++; if (inst_out !== prog[i]) begin errors++; $display("FAIL seq_inst[%0d]: got %h expected %h", i, inst_out, prog[i]); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, inst_valid); end
    end
    checks++; if (fetch_cnt !== 16'd8) begin errors++; $display("FAIL seq_cnt_pre: got %0d expected 8", fetch_cnt); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd9) begin errors++; $display("FAIL seq_cnt: got %0d expected 9", fetch_cnt); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_drain_valid: got %b expected 0", inst_valid); end
  endtask

  task automatic test_wrap();
    fetch_req = 1'b1; fetch_adr = 32'd36;
    tick();
    checks++; if (inst_out !== 32'h00410021) begin errors++; $display("FAIL wrap_36: got %h expected 00410021", inst_out); end
    fetch_adr = 32'd40;
    tick();
    checks++; if (inst_out !== 32'h010B5022) begin errors++; $display("FAIL wrap_40: got %h expected 010b5022", inst_out); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd11) begin errors++; $display("FAIL wrap_cnt: got %0d expected 11", fetch_cnt); end
  endtask

  task automatic test_stall_hold();
    fetch_req = 1'b1; fetch_adr = 32'd8;
    tick();
    checks++; if (inst_out !== 32'h010C5024) begin errors++; $display("FAIL stall_first: got %h expected 010c5024", inst_out); end
    stall = 1'b1; fetch_adr = 32'd12;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", fetch_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst_out !== 32'h010C5024) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected 010c5024", i, inst_out); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, inst_valid); end
      checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, fetch_ready); end
      checks++; if (fetch_cnt !== 16'd11) begin errors++; $display("FAIL stall_cnt[%0d]: got %0d expected 11", i, fetch_cnt); end
    end
    stall = 1'b0;
    tick();
    checks++; if (inst_out !== 32'h014B5825) begin errors++; $display("FAIL stall_release: got %h expected 014b5825", inst_out); end
    checks++; if (fetch_cnt !== 16'd12) begin errors++; $display("FAIL stall_release_cnt: got %0d expected 12", fetch_cnt); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd13) begin errors++; $display("FAIL stall_drain_cnt: got %0d expected 13", fetch_cnt); end
  endtask

  task automatic test_misaligned();
    fetch_req = 1'b1; fetch_adr = 32'd6;
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b expected 1", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL mis_inst: got %h expected 00000000", inst_out); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
    fetch_adr = 32'd16;
    tick();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
    checks++; if (inst_out !== 32'h016C602A) begin errors++; $display("FAIL mis_next: got %h expected 016c602a", inst_out); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd15) begin errors++; $display("FAIL mis_cnt: got %0d expected 15", fetch_cnt); end
  endtask

  task automatic test_collision();
    load_en = 1'b1; load_adr = 32'd20; load_data = 32'hDEADBEEF;
    fetch_req = 1'b1; fetch_adr = 32'd20;
    tick();
    checks++; if (inst_out !== 32'hDEADBEEF) begin errors++; $display("FAIL coll_bypass: got %h expected deadbeef", inst_out); end
    load_en = 1'b0;
    tick();
    checks++; if (inst_out !== 32'hDEADBEEF) begin errors++; $display("FAIL coll_refetch: got %h expected deadbeef", inst_out); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd17) begin errors++; $display("FAIL coll_cnt: got %0d expected 17", fetch_cnt); end
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_adr = 32'd4;
    tick();
    stall = 1'b1; fetch_req = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", inst_valid); end
    reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL mid_inst: got %h expected 00000000", inst_out); end
    checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", fetch_cnt); end
    #1;
    reset = 1'b0; stall = 1'b0;
    fetch_req = 1'b1; fetch_adr = 32'd0;
    tick();
    checks++; if (inst_out !== 32'h00410021) begin errors++; $display("FAIL mid_mem_kept: got %h expected 00410021", inst_out); end
    fetch_req = 1'b0;
    tick();
    checks++; if (fetch_cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt_after: got %0d expected 1", fetch_cnt); end
  endtask

  initial begin
    prog[0] = 32'h00410021;
    prog[1] = 32'h010B5022;
    prog[2] = 32'h010C5024;
    prog[3] = 32'h014B5825;
    prog[4] = 32'h016C602A;
    prog[5] = 32'h8C0D0004;
    prog[6] = 32'hAC0E0008;
    prog[7] = 32'h01CF7820;
    prog[8] = 32'h10840002;
    test_reset();
    load_program();
    test_sequential();
    test_wrap();
    test_stall_hold();
    test_misaligned();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
